sw_to_fw_cmd_decoder: RTL and testbench
=======================================

Name: sw_to_fw_cmd_decoder

Overview:
Upstream command stage for all per-IP firmware blocks (fw_ip1..fw_ip15). It takes the 32-bit software command word written over AXI and decodes device ID and op code. It then issues a one-cycle op-code strobe to the addressed firmware block and feeds the 24-bit payload through. For read op codes it captures that block's read data and status, and it reports them back to software.

Parameters:
NUM_FW, 15, number of attached firmware blocks; device IDs 1..NUM_FW are valid.
RD_LATENCY, 2, cycles from op-code strobe to read-data capture; legal range 1..15.
DROP_CNT_W, 8, width of the saturating dropped-command counter.

Ports:
fw_clk  in  1  FW clock, mapped to S_AXI_ACLK.
fw_rst  in  1  synchronous active-high reset.
sw_write32_0  in  32  command word: [31:28] dev_id, [27:24] op_code, [23:0] payload.
sw_write_valid  in  1  one-cycle strobe; sw_write32_0 is valid in the same cycle.
fw_dev_id_enable  out  NUM_FW  one-hot select; bit i addresses device i+1.
fw_op_code_pulse  out  16  one-hot, single-cycle op-code strobe.
sw_write24_0  out  24  registered payload feed-through.
fw_read_data32_all  in  32*NUM_FW  flattened read data; slice i belongs to device i+1.
fw_read_status32_all  in  32*NUM_FW  flattened read status, same slicing.
sw_read_data32  out  32  captured read data.
sw_read_status32  out  32  registered status of the selected device.
cmd_busy  out  1  high from command acceptance until return to IDLE.
cmd_error  out  1  sticky; set on an invalid dev_id or op_code 0xF.
cmd_drop_cnt  out  DROP_CNT_W  number of commands dropped while busy; saturates.

Behaviour:
- Reset values (fw_rst sampled high on a fw_clk edge): all outputs 0; FSM returns to IDLE; dev select cleared. Reset mid-command aborts with no strobe and no capture.
- Op-code map, one fw_op_code_pulse bit per code:
  - 0 w_reset, 1 w_cfg_static_0, 2 r_cfg_static_0, 3 w_cfg_static_1, 4 r_cfg_static_1
  - 5 w_cfg_array_0, 6 r_cfg_array_0, 7 w_cfg_array_1, 8 r_cfg_array_1
  - 9 w_cfg_array_2, A r_cfg_array_2, B r_data_array_0, C r_data_array_1
  - D w_status_clear, E w_execute, F reserved.
- Read class: op codes 2, 4, 6, 8, A, B, C. All other valid codes are write class.
- FSM states: IDLE, DECODE, STROBE, WAIT_RD, CAPTURE.
  - IDLE: on sw_write_valid, register the word, set cmd_busy, go to DECODE (cycle N+1).
  - DECODE:
    - dev_id in 1..NUM_FW and op_code != F: drive fw_dev_id_enable and sw_write24_0, go to STROBE.
    - otherwise: set cmd_error; fw_dev_id_enable and sw_write24_0 stay unchanged; return to IDLE with no strobe.
  - STROBE: fw_op_code_pulse is asserted for exactly this one cycle (cycle N+2). Write class returns to IDLE; read class goes to WAIT_RD with the counter loaded to RD_LATENCY-1.
  - WAIT_RD: decrement the counter; at 0 go to CAPTURE.
  - CAPTURE: sw_read_data32 <= selected slice of fw_read_data32_all; return to IDLE.
- Capture timing: the capture edge is the end of cycle N+2+RD_LATENCY, so the value is visible from cycle N+3+RD_LATENCY.
- cmd_busy: high from the cycle after acceptance through the last non-IDLE cycle. In total it is high for 2 cycles (write), 2+RD_LATENCY cycles (read) or 1 cycle (error).
- fw_dev_id_enable: a held level, not a pulse. It keeps the last valid selection until the next valid command or reset.
- sw_read_status32: registered every cycle from the slice selected by fw_dev_id_enable; 0 if nothing is selected.
- sw_read_data32: held between captures; write-class commands do not change it.
- sw_write_valid while cmd_busy: command ignored; cmd_drop_cnt increments, saturating at all-ones.
- sw_write_valid in the same cycle the FSM returns to IDLE: treated as busy and dropped. Software spaces commands by at least cmd_busy low.
- cmd_error: cleared only by reset or by an accepted valid command with op code D.

Test Plan:
1. Write 0x3_1_ABCDEF on cycle 0. Required: fw_dev_id_enable=0x0004 from cycle 2; sw_write24_0=0xABCDEF; fw_op_code_pulse=0x0002 on cycle 2 only; cmd_busy high on cycles 1–2.
2. Read 0x5_6_000000 with RD_LATENCY=2 and slice 4 = 0xDEADBEEF. Required: pulse bit 6 on cycle 2; sw_read_data32=0xDEADBEEF from cycle 5; cmd_busy high on cycles 1–4.
3. dev_id 0 and dev_id 0xF (NUM_FW=15, op code F): no pulse, cmd_error=1, previous select retained. A following 0x2_D_000000 clears cmd_error and pulses bit 13.
4. Three sw_write_valid strobes on consecutive cycles. Required: only the first executes; cmd_drop_cnt=2. With DROP_CNT_W=2 and 5 drops, the counter reads 3.
5. Assert fw_rst during WAIT_RD. Required: no capture, all outputs 0 the next cycle; a fresh read afterwards works normally.
6. Select device 7, then change slice 6 status to 0x12345678. Required: sw_read_status32 follows exactly one cycle later.

Source files
------------

// File: rtl/sw_to_fw_cmd_decoder.sv
// Software command decoder: splits the AXI command word into device select, a one-cycle
// op-code strobe and a payload, then captures read data for read-class op codes.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// S_IDLE    | waiting for sw_write_valid; command word captured on acceptance
// S_DECODE  | check dev_id/op_code; drive select and payload or flag error
// S_STROBE  | fw_op_code_pulse high for this single cycle
// S_WAIT_RD | read latency down-counter running
// S_CAPTURE | sample selected read-data slice into sw_read_data32
module sw_to_fw_cmd_decoder #(
   parameter int NUM_FW     = 15,
   parameter int RD_LATENCY = 2,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  fw_clk,
   input  logic                  fw_rst,
   input  logic [31:0]           sw_write32_0,
   input  logic                  sw_write_valid,
   output logic [NUM_FW-1:0]     fw_dev_id_enable,
   output logic [15:0]           fw_op_code_pulse,
   output logic [23:0]           sw_write24_0,
   input  logic [32*NUM_FW-1:0]  fw_read_data32_all,
   input  logic [32*NUM_FW-1:0]  fw_read_status32_all,
   output logic [31:0]           sw_read_data32,
   output logic [31:0]           sw_read_status32,
   output logic                  cmd_busy,
   output logic                  cmd_error,
   output logic [DROP_CNT_W-1:0] cmd_drop_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_STROBE,
      S_WAIT_RD,
      S_CAPTURE
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);

   state_t                state_q, state_d;
   logic [31:0]           cmd_q, cmd_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [NUM_FW-1:0]     dev_en_q, dev_en_d;
   logic [15:0]           pulse_q, pulse_d;
   logic [23:0]           wr24_q, wr24_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic [31:0]           rd_status_q, rd_status_d;
   logic                  error_q, error_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   logic [3:0]            dev_id;
   logic [3:0]            op_code;
   logic                  cmd_ok;
   logic                  is_read;
   logic [NUM_FW-1:0]     dev_onehot;
   logic [31:0]           sel_data;
   logic [31:0]           sel_status;

   assign dev_id  = cmd_q[31:28];
   assign op_code = cmd_q[27:24];
   assign cmd_ok  = (dev_id != 4'd0) && (int'(dev_id) <= NUM_FW) && (op_code != 4'hF);
   assign is_read = op_code inside {4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB, 4'hC};

   always_comb begin
      dev_onehot = '0;
      for (int i = 0; i < NUM_FW; i++) begin
         dev_onehot[i] = (dev_id == 4'(i + 1));
      end
   end

   // Held select is one-hot, so OR-ing the enabled slices is a clean mux.
   always_comb begin
      sel_data   = '0;
      sel_status = '0;
      for (int i = 0; i < NUM_FW; i++) begin
         if (dev_en_q[i]) begin
            sel_data   = sel_data   | fw_read_data32_all[32*i +: 32];
            sel_status = sel_status | fw_read_status32_all[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      dev_en_d    = dev_en_q;
      pulse_d     = '0;
      wr24_d      = wr24_q;
      rd_data_d   = rd_data_q;
      rd_status_d = sel_status;
      error_d     = error_q;
      drop_d      = drop_q;

      unique case (state_q)
         S_IDLE: begin
            if (sw_write_valid) begin
               cmd_d   = sw_write32_0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cmd_ok) begin
               dev_en_d = dev_onehot;
               wr24_d   = cmd_q[23:0];
               pulse_d  = 16'h0001 << op_code;
               if (op_code == 4'hD) begin
                  error_d = 1'b0;
               end
               state_d = S_STROBE;
            end else begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_STROBE: begin
            if (!is_read) begin
               state_d = S_IDLE;
            end else if (WAIT_LOAD == 4'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d   = WAIT_LOAD;
               state_d = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_d == 4'd0) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            rd_data_d = sel_data;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Any strobe outside IDLE, including the last busy cycle, is dropped.
      if (sw_write_valid && (state_q != S_IDLE) && (drop_q != {DROP_CNT_W{1'b1}})) begin
         drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge fw_clk) begin
      if (fw_rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         cnt_q       <= '0;
         dev_en_q    <= '0;
         pulse_q     <= '0;
         wr24_q      <= '0;
         rd_data_q   <= '0;
         rd_status_q <= '0;
         error_q     <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         dev_en_q    <= dev_en_d;
         pulse_q     <= pulse_d;
         wr24_q      <= wr24_d;
         rd_data_q   <= rd_data_d;
         rd_status_q <= rd_status_d;
         error_q     <= error_d;
         drop_q      <= drop_d;
      end
   end

   assign fw_dev_id_enable = dev_en_q;
   assign fw_op_code_pulse = pulse_q;
   assign sw_write24_0     = wr24_q;
   assign sw_read_data32   = rd_data_q;
   assign sw_read_status32 = rd_status_q;
   assign cmd_busy         = (state_q != S_IDLE);
   assign cmd_error        = error_q;
   assign cmd_drop_cnt     = drop_q;

endmodule

// File: tb/tb_sw_to_fw_cmd_decoder.sv
// Bench for sw_to_fw_cmd_decoder: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-timeline model of the decoder.
module tb_sw_to_fw_cmd_decoder;

   localparam int NUM_FW = 15;
   localparam int RL     = 2;

   logic                 fw_clk = 1'b0;
   logic                 fw_rst;
   logic [31:0]          sw_write32_0;
   logic                 sw_write_valid;
   logic [32*NUM_FW-1:0] data_all;
   logic [32*NUM_FW-1:0] stat_all;

   logic [NUM_FW-1:0]    en,     en2;
   logic [15:0]          pulse,  pulse2;
   logic [23:0]          wr24,   wr24_2;
   logic [31:0]          rdata,  rdata2;
   logic [31:0]          rstat,  rstat2;
   logic                 busy,   busy2;
   logic                 err,    err2;
   logic [7:0]           drop;
   logic [1:0]           drop2;

   always #5 fw_clk = ~fw_clk;

   sw_to_fw_cmd_decoder #(.NUM_FW(NUM_FW), .RD_LATENCY(RL), .DROP_CNT_W(8)) dut (
      .fw_clk(fw_clk), .fw_rst(fw_rst),
      .sw_write32_0(sw_write32_0), .sw_write_valid(sw_write_valid),
      .fw_dev_id_enable(en), .fw_op_code_pulse(pulse), .sw_write24_0(wr24),
      .fw_read_data32_all(data_all), .fw_read_status32_all(stat_all),
      .sw_read_data32(rdata), .sw_read_status32(rstat),
      .cmd_busy(busy), .cmd_error(err), .cmd_drop_cnt(drop)
   );

   sw_to_fw_cmd_decoder #(.NUM_FW(NUM_FW), .RD_LATENCY(RL), .DROP_CNT_W(2)) dut2 (
      .fw_clk(fw_clk), .fw_rst(fw_rst),
      .sw_write32_0(sw_write32_0), .sw_write_valid(sw_write_valid),
      .fw_dev_id_enable(en2), .fw_op_code_pulse(pulse2), .sw_write24_0(wr24_2),
      .fw_read_data32_all(data_all), .fw_read_status32_all(stat_all),
      .sw_read_data32(rdata2), .sw_read_status32(rstat2),
      .cmd_busy(busy2), .cmd_error(err2), .cmd_drop_cnt(drop2)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // Model: expected outputs for the current cycle, plus one in-flight command timeline.
   int          m_dev;
   logic [15:0] m_pulse;
   logic [23:0] m_wr24;
   logic [31:0] m_data;
   logic [31:0] m_status;
   logic        m_err;
   logic        m_busy;
   int          m_drop;
   int          m_drop2;
   bit          p_active;
   int          p_acc, p_last, p_dev, p_op;
   bit          p_ok, p_read;
   logic [23:0] p_pay;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] m_en32();
      return (m_dev == 0) ? 32'h0 : (32'h1 << (m_dev - 1));
   endfunction

   task automatic model_reset();
      m_dev = 0; m_pulse = '0; m_wr24 = '0; m_data = '0; m_status = '0;
      m_err = 1'b0; m_busy = 1'b0; m_drop = 0; m_drop2 = 0; p_active = 1'b0;
   endtask

   // Called just after an edge; the bench inputs still hold the previous cycle's values.
   task automatic model_advance();
      int  dev, op;
      bit  prev_busy;
      prev_busy = m_busy;
      if (fw_rst) begin
         model_reset();
         return;
      end
      m_status = (m_dev == 0) ? 32'h0 : stat_all[32*(m_dev-1) +: 32];
      if (p_active && p_ok && p_read && cyc == p_acc + 3 + RL)
         m_data = data_all[32*(m_dev-1) +: 32];
      m_pulse = '0;
      if (p_active && cyc == p_acc + 2) begin
         if (p_ok) begin
            m_dev   = p_dev;
            m_wr24  = p_pay;
            m_pulse = 16'h1 << p_op;
            if (p_op == 13) m_err = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end
      if (sw_write_valid) begin
         if (prev_busy) begin
            if (m_drop  < 255) m_drop++;
            if (m_drop2 < 3)   m_drop2++;
         end else begin
            dev      = int'(sw_write32_0[31:28]);
            op       = int'(sw_write32_0[27:24]);
            p_active = 1'b1;
            p_acc    = cyc - 1;
            p_dev    = dev;
            p_op     = op;
            p_pay    = sw_write32_0[23:0];
            p_ok     = (dev >= 1) && (dev <= NUM_FW) && (op != 15);
            p_read   = op inside {2, 4, 6, 8, 10, 11, 12};
            p_last   = p_acc + (!p_ok ? 1 : (p_read ? 2 + RL : 2));
         end
      end
      m_busy = p_active && (cyc >= p_acc + 1) && (cyc <= p_last);
   endtask

   task automatic tick();
      @(posedge fw_clk);
      #1;
      cyc++;
      model_advance();
   endtask

   task automatic cmd(input logic [31:0] w);
      sw_write32_0   = w;
      sw_write_valid = 1'b1;
      tick();
      sw_write_valid = 1'b0;
   endtask

   always @(negedge fw_clk) begin
      if (chk_en) begin
         chk("dev_en",     32'(en),     m_en32());
         chk("op_pulse",   32'(pulse),  32'(m_pulse));
         chk("wr24",       32'(wr24),   32'(m_wr24));
         chk("rd_data",    rdata,       m_data);
         chk("rd_status",  rstat,       m_status);
         chk("busy",       32'(busy),   32'(m_busy));
         chk("error",      32'(err),    32'(m_err));
         chk("drop_cnt",   32'(drop),   32'(m_drop));
         chk("dev_en_w2",  32'(en2),    m_en32());
         chk("pulse_w2",   32'(pulse2), 32'(m_pulse));
         chk("wr24_w2",    32'(wr24_2), 32'(m_wr24));
         chk("rdata_w2",   rdata2,      m_data);
         chk("rstat_w2",   rstat2,      m_status);
         chk("busy_w2",    32'(busy2),  32'(m_busy));
         chk("error_w2",   32'(err2),   32'(m_err));
         chk("drop_cnt_w2", 32'(drop2), 32'(m_drop2));
      end
   end

   initial begin
      model_reset();
      fw_rst         = 1'b1;
      sw_write_valid = 1'b0;
      sw_write32_0   = '0;
      for (int i = 0; i < NUM_FW; i++) begin
         data_all[32*i +: 32] = 32'hD000_0000 + 32'(i);
         stat_all[32*i +: 32] = 32'h5000_0000 + 32'(i);
      end
      tick();
      chk_en = 1'b1;
      tick();
      fw_rst = 1'b0;
      tick();
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_status", rstat, 32'h0);
      chk("rst_data", rdata, 32'h0);

      // write 0x3_1_ABCDEF
      cmd(32'h31AB_CDEF);
      chk("t1_busy_c1", 32'(busy), 32'h1);
      chk("t1_pulse_c1", 32'(pulse), 32'h0);
      tick();
      chk("t1_en_c2", 32'(en), 32'h0004);
      chk("t1_wr24_c2", 32'(wr24), 32'h00AB_CDEF);
      chk("t1_pulse_c2", 32'(pulse), 32'h0002);
      chk("t1_busy_c2", 32'(busy), 32'h1);
      tick();
      chk("t1_pulse_c3", 32'(pulse), 32'h0);
      chk("t1_busy_c3", 32'(busy), 32'h0);

      // read dev 5, op 6
      data_all[32*4 +: 32] = 32'hDEAD_BEEF;
      cmd(32'h5600_0000);
      tick();
      chk("t2_pulse_c2", 32'(pulse), 32'h0040);
      tick();
      tick();
      chk("t2_busy_c4", 32'(busy), 32'h1);
      chk("t2_data_c4", rdata, 32'h0);
      tick();
      chk("t2_data_c5", rdata, 32'hDEAD_BEEF);
      chk("t2_busy_c5", 32'(busy), 32'h0);

      // invalid dev ids, then status clear
      cmd(32'h0100_0000);
      tick();
      chk("t3a_err", 32'(err), 32'h1);
      chk("t3a_en", 32'(en), 32'h0010);
      chk("t3a_pulse", 32'(pulse), 32'h0);
      chk("t3a_busy", 32'(busy), 32'h0);
      cmd(32'hFF00_0000);
      tick();
      chk("t3b_err", 32'(err), 32'h1);
      chk("t3b_en", 32'(en), 32'h0010);
      chk("t3b_pulse", 32'(pulse), 32'h0);
      cmd(32'h2D00_0000);
      tick();
      chk("t3c_pulse", 32'(pulse), 32'h2000);
      chk("t3c_err", 32'(err), 32'h0);
      chk("t3c_en", 32'(en), 32'h0002);
      tick();

      // back-to-back strobes
      sw_write32_0   = 32'h1100_0001;
      sw_write_valid = 1'b1;
      tick(); tick(); tick();
      sw_write_valid = 1'b0;
      chk("t4_drop_a", 32'(drop), 32'd2);
      chk("t4_drop2_a", 32'(drop2), 32'd2);
      sw_write32_0   = 32'h5600_0000;
      sw_write_valid = 1'b1;
      tick(); tick(); tick(); tick();
      sw_write_valid = 1'b0;
      chk("t4_drop_b", 32'(drop), 32'd5);
      chk("t4_drop2_sat", 32'(drop2), 32'd3);
      tick();

      // reset during WAIT_RD
      data_all[32*4 +: 32] = 32'h1357_9BDF;
      cmd(32'h5600_0000);
      tick();
      tick();
      fw_rst = 1'b1;
      tick();
      fw_rst = 1'b0;
      chk("t5_en", 32'(en), 32'h0);
      chk("t5_wr24", 32'(wr24), 32'h0);
      chk("t5_data", rdata, 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_drop", 32'(drop), 32'h0);
      chk("t5_pulse", 32'(pulse), 32'h0);
      data_all[32*4 +: 32] = 32'hCAFE_F00D;
      cmd(32'h5600_0000);
      tick(); tick(); tick(); tick();
      chk("t5_fresh_data", rdata, 32'hCAFE_F00D);
      chk("t5_fresh_busy", 32'(busy), 32'h0);

      // status follows selected slice one cycle later
      stat_all[32*6 +: 32] = 32'h1111_1111;
      cmd(32'h7100_0000);
      tick();
      tick();
      chk("t6_status_old", rstat, 32'h1111_1111);
      stat_all[32*6 +: 32] = 32'h1234_5678;
      tick();
      chk("t6_status_new", rstat, 32'h1234_5678);

      for (int n = 0; n < 4000; n++) begin
         fw_rst         = ($urandom_range(0, 299) == 0);
         sw_write_valid = ($urandom_range(0, 2) == 0);
         sw_write32_0   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 24'($urandom)};
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < NUM_FW; i++) begin
               data_all[32*i +: 32] = $urandom;
               stat_all[32*i +: 32] = $urandom;
            end
         end
         tick();
      end
      fw_rst         = 1'b0;
      sw_write_valid = 1'b0;
      tick();
      tick();
      @(negedge fw_clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
